golden_nonce_tx_queue: RTL
==========================

# golden_nonce_tx_queue

Buffers golden nonces reported by the hashing cores and hands them one at a time to the serial core's transmit side as 32-bit words. It sits directly upstream of the serial core's TX handler: it drives `word`/`tx_ready` and watches `tx_busy`. It absorbs bursts of nonces that arrive while the UART is still shifting out a previous 4-byte result. It also drops stale results when new work is loaded.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; must be a power of two, 2..16.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`.

Ports:
- `clk`  in  1  single system clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `nonce_in`  in  32  golden nonce from a hashing core.
- `nonce_valid`  in  1  one-cycle strobe qualifying `nonce_in`.
- `flush`  in  1  one-cycle strobe on new work load; discards queued nonces.
- `tx_busy`  in  1  serial core TX busy.
- `word`  out  32  nonce presented to the serial core.
- `tx_ready`  out  1  one-cycle request to the serial core.
- `count`  out  CNT_W  queued entries, excluding the one in flight.
- `overflow`  out  1  sticky; a nonce was dropped because the queue was full.

## Operation
- Storage is a circular FIFO of DEPTH x 32. Write and read pointers are CNT_W bits wide, with a wrap bit.
  - full = MSBs differ and the low bits are equal.
  - empty = the pointers are equal.
- Push: `nonce_valid` and not full writes `nonce_in`.
  - Push while full drops the nonce and sets `overflow`. Stored data is not modified.
  - Push while full in the same cycle as a pop is accepted, because the pop frees the slot first.
- Flush clears both pointers and `overflow` in one cycle.
  - `nonce_valid` in the same cycle as `flush` is dropped; the flush wins.
  - Flush does not abort a word already requested. The FSM completes its handshake.
- FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
  - IDLE: if not empty and `tx_busy`==0, pop the head into the `word` register, then go to REQ.
  - REQ: `tx_ready`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy`=1, go to WAIT_DONE. If `tx_busy` has not risen within 4 cycles of REQ, return to IDLE. The word is considered sent and is not retried.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `word` holds its value from REQ until the next pop. It is never altered while `tx_ready`=1.
- Bytes leave MSB first; the serial core does this. This block does no byte swapping.

## Timing
- Reset values: `word`=0, `tx_ready`=0, `count`=0, `overflow`=0, FSM=IDLE, pointers=0.
- Push to `count` increment: 1 cycle (registered).
- Queue non-empty and idle to `tx_ready`: 2 cycles. Cycle 1 is the IDLE pop; cycle 2 is REQ.
- `nonce_valid` into an empty queue to `tx_ready` high: 3 cycles.
- The serial core raises `tx_busy` 1 cycle after `tx_ready`. The next `tx_ready` comes no sooner than 2 cycles after `tx_busy` falls.
- Back-to-back words: the minimum gap between `tx_ready` pulses is one full 4-byte UART transfer plus 3 cycles.
- Asserting `rst_n` mid-transfer returns to IDLE at once and empties the queue. The serial core finishes any byte independently.

## Structure
- Package `miner_pkg`:
  - FSM state typedef (2-bit enum: IDLE, REQ, WAIT_BUSY, WAIT_DONE).
  - `NONCE_W`=32.
  - `BUSY_TIMEOUT`=4.
- Sub-module `nonce_fifo`: parameterised by DEPTH and width, with push, pop, flush, full, empty and count. The top level holds the FSM, the overflow flag and the word register.

## Test plan
- Single nonce:
  - Stimulus: push 0x0000318F with the serial core model idle.
  - Response: `tx_ready` pulses 3 cycles later with `word`=0x0000318F; `count` returns to 0; `overflow`=0.
- Burst:
  - Stimulus: push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles while `tx_busy`=1.
  - Response: `count`=3, then three `tx_ready` pulses in push order, each only after `tx_busy` has fallen.
- Overflow (DEPTH=4):
  - Stimulus: hold `tx_busy`=1 and push 6 nonces A..F.
  - Response: `overflow`=1 and `count`=4; transmitted order is A, B, C, D.
- Flush mid-transfer:
  - Stimulus: queue 3 nonces, then assert `flush` during WAIT_DONE of the first, in the same cycle as a `nonce_valid`.
  - Response: the first word completes; no further `tx_ready`; `count`=0; `overflow` cleared.
- Busy timeout:
  - Stimulus: the serial core model ignores `tx_ready`.
  - Response: the FSM returns to IDLE within 4 cycles, and the next queued nonce is requested 2 cycles later.
- Async reset:
  - Stimulus: drop `rst_n` in REQ.
  - Response: `tx_ready`=0 immediately with no clock edge, and all outputs hold their reset values.

Source files
------------

// File: rtl/golden_nonce_tx_queue_pkg.sv
// Shared definitions for the golden-nonce transmit path: nonce width,
// the busy-handshake timeout and the transmit FSM state encoding.
package miner_pkg;

  // Width of one golden nonce as handed to the serial core.
  localparam int NONCE_W = 32;

  // Cycles (counting the request cycle) the serial core has to raise
  // tx_busy before the request is abandoned.
  localparam int BUSY_TIMEOUT = 4;

  // Transmit handshake states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/golden_nonce_tx_queue_nonce_fifo.sv
// Circular FIFO for golden nonces. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter. A pop
// frees its slot before a simultaneous push is judged, so a full queue
// still accepts a push in the cycle it pops. Flush empties it in one cycle.
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NONCE_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = CNT_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[CNT_W-1] != rd_ptr_reg[CNT_W-1]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // Flush wins over both operations; the pop is evaluated first so it can
  // make room for a push arriving while full.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Head of queue; the consumer registers it when it pops.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array, written only on an accepted push (no reset so it maps to RAM).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update: flush returns both to zero, otherwise advance on activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/golden_nonce_tx_queue.sv
// Queues golden nonces from the hashing cores and feeds them one at a time
// to the serial core TX handler through a tx_ready / tx_busy handshake.
// A request the serial core never acknowledges is abandoned after a short
// timeout and not retried. Overflow is sticky until the next flush.
module golden_nonce_tx_queue
  import miner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic               nonce_valid,
  input  logic               flush,
  input  logic               tx_busy,
  output logic [NONCE_W-1:0] word,
  output logic               tx_ready,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e          state_reg;
  tx_state_e          state_next;
  logic [TMR_W-1:0]   timer_reg;
  logic [TMR_W-1:0]   timer_next;
  logic [NONCE_W-1:0] word_reg;
  logic [NONCE_W-1:0] head;
  logic               overflow_reg;
  logic               overflow_next;
  logic               full;
  logic               empty;
  logic               pop;

  // Pop only from IDLE with the serial core free; a flush cycle never pops
  // so nothing from the discarded batch is sent.
  assign pop = (state_reg == IDLE) && !empty && !tx_busy && !flush;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NONCE_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (nonce_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (nonce_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Overflow: cleared by flush, set by a push that finds no free slot.
  always_comb begin
    overflow_next = overflow_reg;
    if (flush) begin
      overflow_next = 1'b0;
    end else if (nonce_valid && full && !pop) begin
      overflow_next = 1'b1;
    end
  end

  // Handshake next-state logic; tx_ready is asserted only in REQ.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    tx_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) state_next = REQ;
      end
      REQ: begin
        tx_ready   = 1'b1;
        timer_next = TMR_W'(1);
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TMR_W'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, timeout timer, presented word and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      word_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      overflow_reg <= overflow_next;
      if (pop) word_reg <= head;
    end
  end

  assign word     = word_reg;
  assign overflow = overflow_reg;

endmodule
